// File: rtl/non_res_div_host.sv
`default_nettype none
// ============================================================================
// Module   : non_res_div_host
// Purpose  : Initiator-side sequencer for an 8-bit non-restoring divider.
//            Screens operands for divide-by-zero and quotient overflow,
//            serialises A/Q/M onto in_bus with a one-cycle begin_div strobe,
//            waits (with timeout) for fin, then captures remainder and
//            quotient beats from out_bus.
// Ports    : clk, rst (async, active-high)
//            start, dividend[15:0], divisor[7:0]      system request
//            busy, done, quotient, remainder           system result
//            err_dbz, err_ovf, err_tmo                 sticky error flags
//            begin_div, in_bus[7:0], fin, out_bus[7:0] divider interface
// Revision : 1.0  initial release
// ============================================================================
module non_res_div_host #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        err_dbz,
    output logic        err_ovf,
    output logic        err_tmo,
    output logic        begin_div,
    output logic [7:0]  in_bus,
    input  logic        fin,
    input  logic [7:0]  out_bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_A  = 3'd1,
        S_LD_Q  = 3'd2,
        S_LD_M  = 3'd3,
        S_WAIT  = 3'd4,
        S_CAP_R = 3'd5,
        S_CAP_Q = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] dividend_q;
    logic [7:0]  divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]  quot_q, rem_q;
    logic        dbz_q, ovf_q, tmo_q;

    // Operand screening on the raw inputs so the decision is made in IDLE.
    // A zero divisor also satisfies the overflow compare, so dbz is tested first.
    logic is_dbz, is_ovf, tmo_hit;
    assign is_dbz  = (divisor == 8'd0);
    assign is_ovf  = (dividend[15:8] >= divisor);
    // fin takes priority over the terminal count.
    assign tmo_hit = !fin && (cnt_q == TMO_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d   = state_q;
        begin_div = 1'b0;
        in_bus    = 8'd0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (is_dbz || is_ovf) ? S_DONE : S_LD_A;
            end
            S_LD_A: begin
                begin_div = 1'b1;
                in_bus    = dividend_q[15:8];
                state_d   = S_LD_Q;
            end
            S_LD_Q: begin
                in_bus  = dividend_q[7:0];
                state_d = S_LD_M;
            end
            S_LD_M: begin
                in_bus  = divisor_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fin)          state_d = S_CAP_R;
                else if (tmo_hit) state_d = S_DONE;
            end
            S_CAP_R: state_d = S_CAP_Q;
            S_CAP_Q: state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q <= 16'd0;
            divisor_q  <= 8'd0;
            cnt_q      <= '0;
            quot_q     <= 8'd0;
            rem_q      <= 8'd0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        dbz_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        tmo_q      <= 1'b0;
                        if (is_dbz) begin
                            dbz_q  <= 1'b1;
                            quot_q <= 8'hFF;
                            rem_q  <= dividend[7:0];
                        end else if (is_ovf) begin
                            ovf_q  <= 1'b1;
                            quot_q <= 8'hFF;
                            rem_q  <= 8'hFF;
                        end
                    end
                end
                S_LD_M: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (tmo_hit) begin
                        tmo_q  <= 1'b1;
                        quot_q <= 8'd0;
                        rem_q  <= 8'd0;
                    end
                end
                S_CAP_R: rem_q  <= out_bus;   // beat 1: A register
                S_CAP_Q: quot_q <= out_bus;   // beat 2: Q register
                default: ;
            endcase
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign err_dbz   = dbz_q;
    assign err_ovf   = ovf_q;
    assign err_tmo   = tmo_q;

endmodule
`default_nettype wire

// File: doc/non_res_div_host.md
Name: non_res_div_host

Overview:
- Initiator-side sequencer for the 8-bit non-restoring divider datapath.
- Accepts a 16-bit dividend and an 8-bit divisor in parallel from the system side.
- Serialises the operands onto the divider's 8-bit in_bus with the begin_div handshake, waits for fin, then collects the remainder and quotient beats from out_bus.
- Screens out divide-by-zero and quotient overflow before launching, and guards against a hung divider with a timeout.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT for fin before aborting with an error.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- dividend  input  16  dividend; [15:8] goes to A, [7:0] goes to Q.
- divisor  input  8  divisor; goes to M.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; results and flags are valid from this cycle on.
- quotient  output  8  registered quotient.
- remainder  output  8  registered remainder.
- err_dbz  output  1  divisor was zero; sticky until the next accepted start.
- err_ovf  output  1  dividend[15:8] >= divisor, so the quotient needs more than 8 bits; sticky.
- err_tmo  output  1  fin not seen within TIMEOUT_CYCLES; sticky.
- begin_div  output  1  launch strobe to the divider.
- in_bus  output  8  operand bus to the divider.
- fin  input  1  divider completion flag.
- out_bus  input  8  result bus from the divider.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs, counters and operand latches go to 0 immediately.
- Reset asserted mid-operation abandons the transfer. No done pulse is issued. The divider shares rst, so both ends restart clean.
- IDLE: on start=1, latch dividend and divisor, clear all three err flags, and screen the operands:
  - divisor==0: set err_dbz, quotient=8'hFF, remainder=dividend[7:0], go to DONE. begin_div is never asserted.
  - else if dividend[15:8] >= divisor: set err_ovf, quotient=8'hFF, remainder=8'hFF, go to DONE. No launch.
  - else go to LD_A.
  - start=1 in any state other than IDLE is ignored.
- LD_A: begin_div=1, in_bus=dividend[15:8]; then LD_Q.
- LD_Q: begin_div=0, in_bus=dividend[7:0]; then LD_M.
- LD_M: in_bus=divisor; clear the timeout counter; then WAIT.
- in_bus is 0 in every other state.
- Launch timing: begin_div is exactly one cycle wide, and the three operand beats occupy three consecutive cycles.
- WAIT: the timeout counter increments each cycle.
  - fin=1: go to CAP_R.
  - Counter reaches TIMEOUT_CYCLES-1 with fin=0: set err_tmo, set quotient=remainder=0, go to DONE.
  - fin=1 on the same cycle as the terminal count: fin wins.
- CAP_R: remainder <= out_bus (beat 1, the A register); go to CAP_Q.
- CAP_Q: quotient <= out_bus (beat 2, the Q register); go to DONE.
- DONE: done=1 for one cycle; go to IDLE. A start in this cycle is ignored.
- busy=1 in LD_A, LD_Q, LD_M, WAIT, CAP_R, CAP_Q and DONE; 0 in IDLE.
- Latency:
  - Normal: start to done = 6 + N cycles, where N is the WAIT cycles up to and including the fin cycle.
  - dbz/ovf: done follows start by 1 cycle.
- quotient and remainder hold their values until the next result is written.

Test Plan:
- dividend=16'h0064 (100), divisor=7 → begin_div high for 1 cycle with in_bus beats 00, 64, 07; after fin, remainder=2, quotient=14 (0x0E); done pulses once; no err flags.
- divisor=0, dividend=16'h1234 → begin_div never asserted; done one cycle after start; err_dbz=1, quotient=FF, remainder=34.
- dividend=16'h0A00, divisor=5 → err_ovf=1, no launch, quotient=FF, remainder=FF.
- Divider model holds fin=0 → err_tmo=1 after exactly 64 WAIT cycles; done pulses; next start clears err_tmo.
- rst pulsed during WAIT → all outputs 0 asynchronously; no done pulse; a fresh start (100/7) completes correctly.
- start pulsed again while busy and during DONE → ignored; exactly one launch and one done per accepted start.
